// File: rtl/nubus_pkg.sv
// Shared types and constants for the NuBus slot arbitration agent.
package nubus_pkg;

  localparam int NUBUS_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    FAIR_WAIT,
    ARB,
    GRANT
  } arb_state_e;

endpackage

// File: rtl/nubus_arbiter_if.sv
// Bus-side and master-side signals of one slot's arbitration agent.
interface nubus_arbiter_if
  import nubus_pkg::*;
#(
  parameter int ID_W = NUBUS_ID_W
);

  logic [ID_W-1:0] nub_idn;
  logic [ID_W-1:0] nub_arbn;
  logic            nub_rqstn;
  logic            nub_startn;
  logic            arbcy;
  logic [ID_W-1:0] arb_oe;
  logic            rqst_oe;
  logic            arb_grant;
  logic            fair_wait;

  // The arbiter agent itself
  modport slave (
    input  nub_idn, nub_arbn, nub_rqstn, nub_startn, arbcy,
    output arb_oe, rqst_oe, arb_grant, fair_wait
  );

  // The master controller and bus environment around the agent
  modport master (
    output nub_idn, nub_arbn, nub_rqstn, nub_startn, arbcy,
    input  arb_oe, rqst_oe, arb_grant, fair_wait
  );

endinterface

// File: rtl/nubus_arb_resolve.sv
// Combinational NuBus /ARB contest: a bit is driven only while no higher bit
// shows a competitor asserting a line this slot does not own.
module nubus_arb_resolve #(
  parameter int ID_W = 4
) (
  input  logic [ID_W-1:0] id,
  input  logic [ID_W-1:0] bus,
  input  logic            en,
  output logic [ID_W-1:0] arb_oe,
  output logic            match
);

  logic blocked;

  always_comb begin
    blocked = 1'b0;
    arb_oe  = '0;
    for (int i = ID_W - 1; i >= 0; i--) begin
      arb_oe[i] = en & id[i] & ~blocked;
      blocked   = blocked | (bus[i] & ~id[i]);
    end
  end

  assign match = (bus == id);

endmodule

// File: rtl/nubus_arbiter.sv
// NuBus distributed-arbitration agent for one slot.
// Define NUBUS_ARB_FAIR_EN to enable the fairness rule (won flag, FAIR_WAIT).
module nubus_arbiter
  import nubus_pkg::*;
#(
  parameter int ID_W       = NUBUS_ID_W,
  parameter int SETTLE_CYC = 2
) (
  input  logic           clkn,
  input  logic           reset,
  nubus_arbiter_if.slave bus_if
);

  localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ID_W-1:0]  id, bus;
  logic             en, match, arbcy, startn;
  logic             won;

  assign id     = ~bus_if.nub_idn;
  assign bus    = ~bus_if.nub_arbn;
  assign arbcy  = bus_if.arbcy;
  assign startn = bus_if.nub_startn;
  assign en     = (state == ARB) || (state == GRANT);

  assign bus_if.rqst_oe   = en;
  assign bus_if.arb_grant = (state == GRANT);

  nubus_arb_resolve #(.ID_W(ID_W)) u_resolve (
    .id     (id),
    .bus    (bus),
    .en     (en),
    .arb_oe (bus_if.arb_oe),
    .match  (match)
  );

`ifdef NUBUS_ARB_FAIR_EN
  // A win blocks re-requesting until /RQST is seen released while we are off the bus
  always_ff @(posedge clkn or posedge reset) begin
    if (reset) begin
      won <= 1'b0;
    end else if (state == GRANT && !arbcy) begin
      won <= 1'b1;
    end else if (bus_if.nub_rqstn && !bus_if.rqst_oe) begin
      won <= 1'b0;
    end
  end

  assign bus_if.fair_wait = (state == FAIR_WAIT);
`else
  logic unused_rqstn;

  assign won              = 1'b0;
  assign unused_rqstn     = bus_if.nub_rqstn;
  assign bus_if.fair_wait = 1'b0;
`endif

  always_ff @(posedge clkn or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grant is taken on the edge where the settle count reaches zero, so an
  // uncontended request wins SETTLE_CYC+1 edges after arbcy rises.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (arbcy) begin
          if (won) begin
            state_nxt = FAIR_WAIT;
          end else begin
            state_nxt = ARB;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      FAIR_WAIT: begin
        if (!arbcy) begin
          state_nxt = IDLE;
        end else if (bus_if.nub_rqstn) begin
          state_nxt = ARB;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ARB: begin
        if (!startn) begin
          cnt_nxt = CNT_LOAD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end
        if (!arbcy) begin
          state_nxt = IDLE;
        end else if (startn && (cnt_nxt == '0) && match) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!arbcy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nubus_arbiter.sv
// Directed self-checking bench for nubus_arbiter; bus lines are modelled as
// wired-OR of this slot's drives and an external competitor.
module tb_nubus_arbiter;
  import nubus_pkg::*;

  localparam int ID_W       = NUBUS_ID_W;
  localparam int SETTLE_CYC = 2;

  logic            clkn = 1'b0;
  logic            reset;
  logic [ID_W-1:0] ext_arb;
  logic            ext_rqst;
  int              tests_run = 0;
  int              tests_failed = 0;

  nubus_arbiter_if #(.ID_W(ID_W)) ifc ();

  nubus_arbiter #(.ID_W(ID_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clkn   (clkn),
    .reset  (reset),
    .bus_if (ifc)
  );

  always #5 clkn = ~clkn;

  // Open-collector lines: low when any slot drives them
  assign #1 ifc.nub_arbn  = ~(ifc.arb_oe | ext_arb);
  assign #1 ifc.nub_rqstn = ~(ifc.rqst_oe | ext_rqst);

  // {arb_grant, rqst_oe, fair_wait, arb_oe}
  wire [6:0] obs = {ifc.arb_grant, ifc.rqst_oe, ifc.fair_wait, ifc.arb_oe};

  task automatic apply_reset(input logic [3:0] id);
    reset          = 1'b1;
    ifc.arbcy      = 1'b0;
    ifc.nub_startn = 1'b1;
    ifc.nub_idn    = ~id;
    ext_arb        = '0;
    ext_rqst       = 1'b0;
    @(negedge clkn);
    reset = 1'b0;
    @(negedge clkn);
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    ifc.arbcy      = 1'b1;
    ifc.nub_startn = 1'b1;
    ifc.nub_idn    = ~4'hA;
    ext_arb        = '0;
    ext_rqst       = 1'b0;
    #1;
    tests_run++;
    if (obs !== 7'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_immediate: got %h expected %h", obs, 7'h00);
    end
    @(negedge clkn);
    @(negedge clkn);
    tests_run++;
    if (obs !== 7'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_held: got %h expected %h", obs, 7'h00);
    end
    ifc.arbcy = 1'b0;
    reset     = 1'b0;
    @(negedge clkn);
  endtask

  task automatic test_single();
    apply_reset(4'hA);
    ifc.arbcy = 1'b1;
    @(negedge clkn);
    tests_run++;
    if (obs !== {3'b010, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL single_edge1: got %h expected %h", obs, {3'b010, 4'hA});
    end
    tests_run++;
    if (ifc.nub_rqstn !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_rqst_line: got %b expected %b", ifc.nub_rqstn, 1'b0);
    end
    @(negedge clkn);
    tests_run++;
    if (obs !== {3'b010, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL single_edge2: got %h expected %h", obs, {3'b010, 4'hA});
    end
    @(negedge clkn);
    tests_run++;
    if (obs !== {3'b110, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL single_grant_edge3: got %h expected %h", obs, {3'b110, 4'hA});
    end
    ifc.arbcy = 1'b0;
    @(negedge clkn);
    tests_run++;
    if (obs !== 7'h00) begin
      tests_failed++;
      $display("[TB] FAIL single_release: got %h expected %h", obs, 7'h00);
    end
  endtask

  task automatic test_contest();
    apply_reset(4'h5);
    ext_arb   = 4'h9;
    ifc.arbcy = 1'b1;
    @(negedge clkn);
    tests_run++;
    if (obs !== 7'b010_0000) begin
      tests_failed++;
      $display("[TB] FAIL contest_lose_edge1: got %h expected %h", obs, 7'b010_0000);
    end
    repeat (3) @(negedge clkn);
    tests_run++;
    if (obs !== 7'b010_0000) begin
      tests_failed++;
      $display("[TB] FAIL contest_no_grant: got %h expected %h", obs, 7'b010_0000);
    end
    // Competitor starts its transaction and leaves arbitration
    ext_arb        = '0;
    ifc.nub_startn = 1'b0;
    @(negedge clkn);
    ifc.nub_startn = 1'b1;
    tests_run++;
    if (obs !== {3'b010, 4'h5}) begin
      tests_failed++;
      $display("[TB] FAIL contest_drive_after_drop: got %h expected %h", obs, {3'b010, 4'h5});
    end
    @(negedge clkn);
    tests_run++;
    if (obs !== {3'b010, 4'h5}) begin
      tests_failed++;
      $display("[TB] FAIL contest_settling: got %h expected %h", obs, {3'b010, 4'h5});
    end
    @(negedge clkn);
    tests_run++;
    if (obs !== {3'b110, 4'h5}) begin
      tests_failed++;
      $display("[TB] FAIL contest_grant: got %h expected %h", obs, {3'b110, 4'h5});
    end
  endtask

  task automatic test_start_reload();
    apply_reset(4'hA);
    ifc.arbcy = 1'b1;
    repeat (2) @(negedge clkn);
    ifc.nub_startn = 1'b0;
    @(negedge clkn);
    ifc.nub_startn = 1'b1;
    tests_run++;
    if (obs !== {3'b010, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL start_blocks_grant: got %h expected %h", obs, {3'b010, 4'hA});
    end
    @(negedge clkn);
    tests_run++;
    if (obs !== {3'b010, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL start_resettle: got %h expected %h", obs, {3'b010, 4'hA});
    end
    @(negedge clkn);
    tests_run++;
    if (obs !== {3'b110, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL start_delayed_grant: got %h expected %h", obs, {3'b110, 4'hA});
    end
  endtask

  task automatic test_fairness();
    logic [6:0] exp1, exp3, exp5;
`ifdef NUBUS_ARB_FAIR_EN
    exp1 = 7'b001_0000;
    exp3 = {3'b010, 4'hA};
    exp5 = {3'b110, 4'hA};
`else
    exp1 = {3'b010, 4'hA};
    exp3 = {3'b110, 4'hA};
    exp5 = {3'b110, 4'hA};
`endif
    apply_reset(4'hA);
    ifc.arbcy = 1'b1;
    repeat (3) @(negedge clkn);
    ext_rqst  = 1'b1;
    ifc.arbcy = 1'b0;
    @(negedge clkn);
    tests_run++;
    if (obs !== 7'h00) begin
      tests_failed++;
      $display("[TB] FAIL fair_release: got %h expected %h", obs, 7'h00);
    end
    ifc.arbcy = 1'b1;
    @(negedge clkn);
    tests_run++;
    if (obs !== exp1) begin
      tests_failed++;
      $display("[TB] FAIL fair_rerequest: got %h expected %h", obs, exp1);
    end
    @(negedge clkn);
    ext_rqst = 1'b0;
    @(negedge clkn);
    tests_run++;
    if (obs !== exp3) begin
      tests_failed++;
      $display("[TB] FAIL fair_rqst_released: got %h expected %h", obs, exp3);
    end
    repeat (2) @(negedge clkn);
    tests_run++;
    if (obs !== exp5) begin
      tests_failed++;
      $display("[TB] FAIL fair_grant: got %h expected %h", obs, exp5);
    end
  endtask

  task automatic test_drop_in_arb();
    apply_reset(4'hA);
    ifc.arbcy = 1'b1;
    @(negedge clkn);
    ifc.arbcy = 1'b0;
    #1;
    tests_run++;
    if (obs !== {3'b010, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL drop_held_until_edge: got %h expected %h", obs, {3'b010, 4'hA});
    end
    @(negedge clkn);
    tests_run++;
    if (obs !== 7'h00) begin
      tests_failed++;
      $display("[TB] FAIL drop_released: got %h expected %h", obs, 7'h00);
    end
    // Never granted, so the slot may re-enter arbitration at once
    ifc.arbcy = 1'b1;
    @(negedge clkn);
    tests_run++;
    if (obs !== {3'b010, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL drop_rearb: got %h expected %h", obs, {3'b010, 4'hA});
    end
  endtask

  task automatic test_reset_in_grant();
    apply_reset(4'hA);
    ifc.arbcy = 1'b1;
    repeat (3) @(negedge clkn);
    tests_run++;
    if (obs !== {3'b110, 4'hA}) begin
      tests_failed++;
      $display("[TB] FAIL rgrant_granted: got %h expected %h", obs, {3'b110, 4'hA});
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (obs !== 7'h00) begin
      tests_failed++;
      $display("[TB] FAIL rgrant_async_release: got %h expected %h", obs, 7'h00);
    end
    @(negedge clkn);
    reset     = 1'b0;
    ifc.arbcy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contest();
    test_start_reload();
    test_fairness();
    test_drop_in_arb();
    test_reset_in_grant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
